// File: rtl/pf_pkg.sv
// Shared defaults and state encoding for the playfield vertical scroll stage.
package pf_pkg;

  localparam int PF_VBITS_DEF     = 9;
  localparam int PF_FINE_BITS_DEF = 3;
  localparam int PF_LINES_DEF     = 512;

  typedef enum logic {
    VBLANK = 1'b0,
    ACTIVE = 1'b1
  } pf_vstate_t;

endpackage

// File: rtl/pf_vwrap_counter.sv
// Loadable modulo-PF_LINES up counter; a load always beats an increment.
module pf_vwrap_counter
  import pf_pkg::*;
#(
  parameter int VBITS    = PF_VBITS_DEF,
  parameter int PF_LINES = PF_LINES_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [VBITS-1:0] i_load_val,
  input  logic             i_inc,
  output logic [VBITS-1:0] o_count
);

  localparam logic [VBITS-1:0] LAST = VBITS'(PF_LINES - 1);

  logic [VBITS-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_inc) begin
      r_count <= (r_count == LAST) ? '0 : r_count + VBITS'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/pf_vscroll_counter.sv
// Playfield vertical scroll: shadowed scroll value committed at vblank end,
// per-line position advance, and a row strobe for the tile fetch stage.
module pf_vscroll_counter
  import pf_pkg::*;
#(
  parameter int VBITS     = PF_VBITS_DEF,
  parameter int FINE_BITS = PF_FINE_BITS_DEF,
  parameter int PF_LINES  = PF_LINES_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_cpu_we,
  input  logic [VBITS-1:0]     i_cpu_data,
  input  logic                 i_vblank_start,
  input  logic                 i_vblank_end,
  input  logic                 i_line_stb,
  output logic [VBITS-1:0]     o_pf_vpos,
  output logic [FINE_BITS-1:0] o_pf_fine,
  output logic [VBITS-FINE_BITS-1:0] o_pf_row,
  output logic                 o_row_stb,
  output logic                 o_scroll_pending,
  output logic                 o_active
);

  localparam logic [VBITS:0] LINES_EXT = (VBITS + 1)'(PF_LINES);

  pf_vstate_t       r_state;
  pf_vstate_t       w_state_next;
  logic [VBITS-1:0] r_shadow;
  logic             r_pending;
  logic             r_load_d;
  logic             r_inc_d;
  logic             r_row_stb;
  logic [VBITS-1:0] w_cpu_norm;
  logic [VBITS-1:0] w_load_val;
  logic [VBITS-1:0] w_count;
  logic             w_inc;
  logic             w_row_req;

  // Single conditional subtract folds an out-of-range write back into the playfield.
  assign w_cpu_norm = ({1'b0, i_cpu_data} >= LINES_EXT) ?
                      (i_cpu_data - LINES_EXT[VBITS-1:0]) : i_cpu_data;

  assign w_load_val = i_cpu_we ? w_cpu_norm : r_shadow;
  assign w_inc      = i_line_stb & (r_state == ACTIVE) & ~i_vblank_end;

  pf_vwrap_counter #(
    .VBITS    (VBITS),
    .PF_LINES (PF_LINES)
  ) u_counter (
    .clk        (clk),
    .reset      (reset),
    .i_load     (i_vblank_end),
    .i_load_val (w_load_val),
    .i_inc      (w_inc),
    .o_count    (w_count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= VBLANK;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (i_vblank_end) begin
      w_state_next = ACTIVE;
    end else if ((r_state == ACTIVE) && i_vblank_start) begin
      w_state_next = VBLANK;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_shadow  <= '0;
      r_pending <= 1'b0;
    end else begin
      if (i_cpu_we) begin
        r_shadow <= w_cpu_norm;
      end
      if (i_vblank_end) begin
        r_pending <= 1'b0;
      end else if (i_cpu_we) begin
        r_pending <= 1'b1;
      end
    end
  end

  // Row strobe looks at the already-updated position, so it trails the load/increment by a cycle.
  assign w_row_req = r_load_d | (r_inc_d & (w_count[FINE_BITS-1:0] == '0));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_load_d  <= 1'b0;
      r_inc_d   <= 1'b0;
      r_row_stb <= 1'b0;
    end else begin
      r_load_d  <= i_vblank_end;
      r_inc_d   <= w_inc;
      r_row_stb <= w_row_req & ~r_row_stb;
    end
  end

  assign o_pf_vpos        = w_count;
  assign o_pf_fine        = w_count[FINE_BITS-1:0];
  assign o_pf_row         = w_count[VBITS-1:FINE_BITS];
  assign o_row_stb        = r_row_stb;
  assign o_scroll_pending = r_pending;
  assign o_active         = (r_state == ACTIVE);

endmodule

// File: tb/tb_pf_vscroll_counter.sv
// Directed bench: a 512-line and a 480-line instance share one stimulus stream.
module tb_pf_vscroll_counter;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       cpuWe = 1'b0;
  logic [8:0] cpuData = '0;
  logic       vblankStart = 1'b0;
  logic       vblankEnd = 1'b0;
  logic       lineStb = 1'b0;

  logic [8:0] vposA, vposB;
  logic [2:0] fineA, fineB;
  logic [5:0] rowA, rowB;
  logic       rowStbA, rowStbB;
  logic       pendA, pendB;
  logic       actA, actB;

  int checkCount = 0;
  int passCount  = 0;

  always #5 clk = ~clk;

  pf_vscroll_counter #(.VBITS(9), .FINE_BITS(3), .PF_LINES(512)) dutA (
    .clk(clk), .reset(reset), .i_cpu_we(cpuWe), .i_cpu_data(cpuData),
    .i_vblank_start(vblankStart), .i_vblank_end(vblankEnd), .i_line_stb(lineStb),
    .o_pf_vpos(vposA), .o_pf_fine(fineA), .o_pf_row(rowA), .o_row_stb(rowStbA),
    .o_scroll_pending(pendA), .o_active(actA)
  );

  pf_vscroll_counter #(.VBITS(9), .FINE_BITS(3), .PF_LINES(480)) dutB (
    .clk(clk), .reset(reset), .i_cpu_we(cpuWe), .i_cpu_data(cpuData),
    .i_vblank_start(vblankStart), .i_vblank_end(vblankEnd), .i_line_stb(lineStb),
    .o_pf_vpos(vposB), .o_pf_fine(fineB), .o_pf_row(rowB), .o_row_stb(rowStbB),
    .o_scroll_pending(pendB), .o_active(actB)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold the given inputs for one clock edge, then return them all to idle.
  task automatic applyStimulus(input logic we, input logic [8:0] data, input logic vend,
                               input logic vstart, input logic line, input logic rst);
    cpuWe = we; cpuData = data; vblankEnd = vend; vblankStart = vstart;
    lineStb = line; reset = rst;
    tick();
    cpuWe = 1'b0; vblankEnd = 1'b0; vblankStart = 1'b0; lineStb = 1'b0; reset = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 9'h0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic pulseLine();
    applyStimulus(1'b0, 9'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
  endtask

  task automatic commit();
    applyStimulus(1'b0, 9'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
  endtask

  task automatic writeScroll(input logic [8:0] data);
    applyStimulus(1'b1, data, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset and idle, including ignored line strobes in vblank.
    doReset();
    tick();
    checkOutput("rst_vpos",    vposA, 0);
    checkOutput("rst_active",  actA, 0);
    checkOutput("rst_rowstb",  rowStbA, 0);
    checkOutput("rst_pending", pendA, 0);
    pulseLine();
    pulseLine();
    checkOutput("vblank_line_hold", vposA, 0);
    checkOutput("vblank_line_rowstb", rowStbA, 0);

    // Write 5, commit, advance three lines to a tile boundary.
    writeScroll(9'h005);
    checkOutput("wr5_pending", pendA, 1);
    tick();
    checkOutput("wr5_pending_hold", pendA, 1);
    applyStimulus(1'b0, 9'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("load5_vpos", vposA, 5);
    checkOutput("load5_pending", pendA, 0);
    checkOutput("load5_active", actA, 1);
    checkOutput("load5_rowstb_early", rowStbA, 0);
    tick();
    checkOutput("load5_rowstb", rowStbA, 1);
    tick();
    checkOutput("load5_rowstb_drop", rowStbA, 0);
    pulseLine();
    checkOutput("line6_vpos", vposA, 6);
    checkOutput("line6_rowstb", rowStbA, 0);
    pulseLine();
    checkOutput("line7_rowstb", rowStbA, 0);
    applyStimulus(1'b0, 9'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("line8_vpos", vposA, 8);
    checkOutput("line8_row", rowA, 1);
    checkOutput("line8_fine", fineA, 0);
    checkOutput("line8_rowstb_early", rowStbA, 0);
    tick();
    checkOutput("line8_rowstb", rowStbA, 1);
    tick();
    checkOutput("line8_rowstb_drop", rowStbA, 0);

    // Wrap at 512: 0x1FE -> 0x1FF -> 0x000 -> 0x001.
    doReset();
    writeScroll(9'h1FE);
    commit();
    tick();
    pulseLine();
    checkOutput("wrap_1ff", vposA, 9'h1FF);
    checkOutput("wrap_1ff_rowstb", rowStbA, 0);
    pulseLine();
    checkOutput("wrap_000", vposA, 9'h000);
    checkOutput("wrap_000_rowstb", rowStbA, 1);
    pulseLine();
    checkOutput("wrap_001", vposA, 9'h001);
    checkOutput("wrap_001_rowstb", rowStbA, 0);

    // Normalisation and wrap on the 480-line instance.
    doReset();
    writeScroll(9'h1F0);
    commit();
    checkOutput("norm480_1f0", vposB, 9'h010);
    checkOutput("norm512_1f0", vposA, 9'h1F0);
    writeScroll(9'h1E0);
    commit();
    checkOutput("norm480_1e0", vposB, 9'h000);
    writeScroll(9'h1DF);
    commit();
    tick();
    checkOutput("load480_1df", vposB, 9'h1DF);
    pulseLine();
    checkOutput("wrap480_vpos", vposB, 0);
    checkOutput("wrap480_rowstb", rowStbB, 1);
    checkOutput("wrap512_vpos", vposA, 9'h1E0);

    // Write, commit and line strobe all in one cycle while active.
    doReset();
    commit();
    applyStimulus(1'b1, 9'h020, 1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("bypass_vpos", vposA, 9'h020);
    checkOutput("bypass_pending", pendA, 0);
    tick();
    checkOutput("bypass_rowstb", rowStbA, 1);
    tick();

    // Line strobe together with vblank start: increment then leave active.
    applyStimulus(1'b0, 9'h0, 1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("vstart_inc_vpos", vposA, 9'h021);
    checkOutput("vstart_inc_active", actA, 0);
    pulseLine();
    checkOutput("vstart_hold", vposA, 9'h021);

    // Both vblank pulses together: the reload wins.
    commit();
    applyStimulus(1'b0, 9'h0, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("both_vblank_active", actA, 1);

    // Reset mid-active with a line strobe pending.
    writeScroll(9'h030);
    commit();
    pulseLine();
    pulseLine();
    pulseLine();
    checkOutput("pre_reset_vpos", vposA, 9'h033);
    applyStimulus(1'b0, 9'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("mid_reset_vpos", vposA, 0);
    checkOutput("mid_reset_active", actA, 0);
    checkOutput("mid_reset_rowstb", rowStbA, 0);
    tick();
    checkOutput("mid_reset_rowstb_after", rowStbA, 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
